fetch_unit_bp: RTL and testbench

Parametrised next-generation fetch unit. It issues word-aligned PC requests to the I$ and pre-decodes the returned instruction. It predicts the next PC using a tagged BTB with N-bit saturating direction counters, immediate j/jal targets, and a bounded RAS with overflow/underflow handling. Each fetched instruction carries RAS checkpoint metadata, so the pipeline can restore the RAS on a resolved redirect. Sits in core between I$ and the decode/dispatch pipeline.

---
 rtl/fetch_unit_bp.sv | 173 +++++++++++++++++
 tb/tb_fetch_unit_bp.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit_bp.sv
// Fetch unit with next-PC prediction.
// A tagged BTB with saturating direction counters predicts branches. j/jal use
// their immediate target. jr returns through a bounded circular RAS.
// Every fetched instruction carries the RAS pointer and count it observed, so
// a resolved redirect can restore the stack.
module fetch_unit_bp #(
   parameter int                  PC_WIDTH       = 14,
   parameter logic [PC_WIDTH+1:0] PC_RESET_VAL   = '0,
   parameter int                  LOG_BTB_FRAMES = 4,
   parameter int                  CTR_WIDTH      = 2,
   parameter int                  LOG_RAS_DEPTH  = 3
) (
   input  logic                     CLK,
   input  logic                     RST,
   output logic                     DUT_error,
   input  logic                     from_pipeline_BTB_DIRP_update,
   input  logic [PC_WIDTH-1:0]      from_pipeline_BTB_DIRP_PC,
   input  logic [PC_WIDTH-1:0]      from_pipeline_BTB_target,
   input  logic                     from_pipeline_DIRP_taken,
   input  logic                     from_pipeline_take_resolved,
   input  logic [PC_WIDTH-1:0]      from_pipeline_resolved_PC,
   input  logic [LOG_RAS_DEPTH-1:0] from_pipeline_RAS_restore_ptr,
   input  logic [LOG_RAS_DEPTH:0]   from_pipeline_RAS_restore_count,
   input  logic                     icache_hit,
   input  logic [31:0]              icache_load,
   output logic                     icache_REN,
   output logic [31:0]              icache_addr,
   output logic                     icache_halt,
   input  logic                     core_control_stall_fetch_unit,
   input  logic                     core_control_halt,
   output logic [31:0]              to_pipeline_instr,
   output logic                     to_pipeline_ivalid,
   output logic [PC_WIDTH-1:0]      to_pipeline_PC,
   output logic [PC_WIDTH-1:0]      to_pipeline_nPC,
   output logic [LOG_RAS_DEPTH-1:0] to_pipeline_RAS_ptr,
   output logic [LOG_RAS_DEPTH:0]   to_pipeline_RAS_count
);
   localparam int NFR       = 2 ** LOG_BTB_FRAMES;
   localparam int RAS_DEPTH = 2 ** LOG_RAS_DEPTH;
   localparam int TAG_W     = PC_WIDTH - LOG_BTB_FRAMES;
   localparam int CW        = LOG_RAS_DEPTH + 1;
   localparam logic [CTR_WIDTH-1:0] CTR_WT   = CTR_WIDTH'(1) << (CTR_WIDTH - 1);
   localparam logic [CTR_WIDTH-1:0] CTR_WNT  = CTR_WT - CTR_WIDTH'(1);
   localparam logic [CW-1:0]        RAS_FULL = CW'(RAS_DEPTH);

   logic [PC_WIDTH-1:0]                 pc_q, pc_d, pc_inc;
   logic [NFR-1:0]                      btb_vld_q;
   logic [NFR-1:0][TAG_W-1:0]           btb_tag_q;
   logic [NFR-1:0][PC_WIDTH-1:0]        btb_tgt_q;
   logic [NFR-1:0][CTR_WIDTH-1:0]       btb_ctr_q;
   logic [RAS_DEPTH-1:0][PC_WIDTH-1:0]  ras_q;
   logic [LOG_RAS_DEPTH-1:0]            ras_ptr_q, ras_top_idx;
   logic [CW-1:0]                       ras_cnt_q, rst_cnt;
   logic                                ren_q, ihalt_q, halted_q, err_q;

   // Pre-decode of the returned word
   logic [5:0] opc, fn;
   logic       is_br, is_j, is_jal, is_jr, accept;
   assign opc    = icache_load[31:26];
   assign fn     = icache_load[5:0];
   assign is_br  = (opc == 6'h04) | (opc == 6'h05);
   assign is_j   = (opc == 6'h02);
   assign is_jal = (opc == 6'h03);
   assign is_jr  = (opc == 6'h00) & (fn == 6'h08);
   assign accept = icache_hit & ~core_control_stall_fetch_unit & ~from_pipeline_take_resolved
                   & ~halted_q & ~core_control_halt;

   // BTB lookup on the fetch PC, and tag compare on the update PC
   logic [LOG_BTB_FRAMES-1:0] lk_idx, up_idx;
   logic [TAG_W-1:0]          lk_tag, up_tag;
   logic                      btb_hit, pred_taken, up_hit;
   assign lk_idx     = pc_q[LOG_BTB_FRAMES-1:0];
   assign lk_tag     = pc_q[PC_WIDTH-1:LOG_BTB_FRAMES];
   assign btb_hit    = btb_vld_q[lk_idx] & (btb_tag_q[lk_idx] == lk_tag);
   assign pred_taken = btb_hit & btb_ctr_q[lk_idx][CTR_WIDTH-1];
   assign up_idx     = from_pipeline_BTB_DIRP_PC[LOG_BTB_FRAMES-1:0];
   assign up_tag     = from_pipeline_BTB_DIRP_PC[PC_WIDTH-1:LOG_BTB_FRAMES];
   assign up_hit     = btb_vld_q[up_idx] & (btb_tag_q[up_idx] == up_tag);

   logic do_push, do_pop, rst_ovf;
   assign pc_inc      = pc_q + PC_WIDTH'(1);
   assign ras_top_idx = ras_ptr_q - LOG_RAS_DEPTH'(1);
   assign do_push     = accept & is_jal;
   assign do_pop      = accept & is_jr & (ras_cnt_q != '0);
   // A checkpoint count larger than the stack is flagged and clamped
   assign rst_ovf     = from_pipeline_RAS_restore_count > RAS_FULL;
   assign rst_cnt     = rst_ovf ? RAS_FULL : from_pipeline_RAS_restore_count;

   // Next-PC selection, redirect first
   always_comb begin
      pc_d = pc_q;
      if (from_pipeline_take_resolved)  pc_d = from_pipeline_resolved_PC;
      else if (accept) begin
         if (is_br)                     pc_d = pred_taken ? btb_tgt_q[lk_idx] : pc_inc;
         else if (is_j | is_jal)        pc_d = icache_load[PC_WIDTH-1:0];
         else if (is_jr)                pc_d = (ras_cnt_q != '0) ? ras_q[ras_top_idx] : pc_inc;
         else                           pc_d = pc_inc;
      end
   end

   // BTB allocate / train; lookups this cycle still see the old contents
   always_ff @(posedge CLK) begin
      if (RST) begin
         btb_vld_q <= '0;
         btb_tag_q <= '0;
         btb_tgt_q <= '0;
         for (int i = 0; i < NFR; i++) btb_ctr_q[i] <= CTR_WNT;
      end else if (from_pipeline_BTB_DIRP_update) begin
         btb_tgt_q[up_idx] <= from_pipeline_BTB_target;
         if (up_hit) begin
            if (from_pipeline_DIRP_taken && btb_ctr_q[up_idx] != '1)
               btb_ctr_q[up_idx] <= btb_ctr_q[up_idx] + CTR_WIDTH'(1);
            else if (!from_pipeline_DIRP_taken && btb_ctr_q[up_idx] != '0)
               btb_ctr_q[up_idx] <= btb_ctr_q[up_idx] - CTR_WIDTH'(1);
         end else begin
            btb_vld_q[up_idx] <= 1'b1;
            btb_tag_q[up_idx] <= up_tag;
            btb_ctr_q[up_idx] <= from_pipeline_DIRP_taken ? CTR_WT : CTR_WNT;
         end
      end
   end

   // Circular RAS: a push when full overwrites the oldest entry
   always_ff @(posedge CLK) begin
      if (RST) begin
         ras_q     <= '0;
         ras_ptr_q <= '0;
         ras_cnt_q <= '0;
      end else if (from_pipeline_take_resolved) begin
         ras_ptr_q <= from_pipeline_RAS_restore_ptr;
         ras_cnt_q <= rst_cnt;
      end else if (do_push) begin
         ras_q[ras_ptr_q] <= pc_inc;
         ras_ptr_q        <= ras_ptr_q + LOG_RAS_DEPTH'(1);
         if (ras_cnt_q != RAS_FULL) ras_cnt_q <= ras_cnt_q + CW'(1);
      end else if (do_pop) begin
         ras_ptr_q <= ras_top_idx;
         ras_cnt_q <= ras_cnt_q - CW'(1);
      end
   end

   // PC, sticky halt, I$ enable and error flag
   always_ff @(posedge CLK) begin
      if (RST) begin
         pc_q     <= PC_RESET_VAL[PC_WIDTH+1:2];
         ren_q    <= 1'b0;
         ihalt_q  <= 1'b0;
         halted_q <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         pc_q  <= pc_d;
         err_q <= from_pipeline_take_resolved & rst_ovf;
         if (core_control_halt | halted_q) begin
            halted_q <= 1'b1;
            ren_q    <= 1'b0;
            ihalt_q  <= 1'b1;
         end else begin
            ren_q    <= 1'b1;
         end
      end
   end

   assign icache_addr           = {{(30 - PC_WIDTH){1'b0}}, pc_q, 2'b00};
   assign icache_REN            = ren_q;
   assign icache_halt           = ihalt_q;
   assign DUT_error             = err_q;
   assign to_pipeline_instr     = icache_load;
   assign to_pipeline_ivalid    = accept;
   assign to_pipeline_PC        = pc_q;
   assign to_pipeline_nPC       = pc_d;
   assign to_pipeline_RAS_ptr   = ras_ptr_q;
   assign to_pipeline_RAS_count = ras_cnt_q;
endmodule

// File: tb/tb_fetch_unit_bp.sv
// Directed bench for fetch_unit_bp. The stimulus pushes the expected fetch
// record for each instruction. A negedge monitor pops and compares a record
// whenever the DUT presents ivalid.
module tb_fetch_unit_bp;
   logic        CLK = 1'b0, RST = 1'b1;
   logic        DUT_error;
   logic        upd = 0, upd_tk = 0, take = 0;
   logic [13:0] upd_pc = 0, upd_tgt = 0, res_pc = 0;
   logic [2:0]  rs_ptr = 0;
   logic [3:0]  rs_cnt = 0;
   logic        icache_hit = 0, icache_REN, icache_halt;
   logic [31:0] icache_load = 0, icache_addr;
   logic        stall = 0, halt = 0;
   logic [31:0] p_instr;
   logic        p_ivalid;
   logic [13:0] p_pc, p_npc;
   logic [2:0]  p_ptr;
   logic [3:0]  p_cnt;

   fetch_unit_bp #(.PC_WIDTH(14), .PC_RESET_VAL(16'h0040), .LOG_BTB_FRAMES(4),
                   .CTR_WIDTH(2), .LOG_RAS_DEPTH(3)) dut (
      .CLK(CLK), .RST(RST), .DUT_error(DUT_error),
      .from_pipeline_BTB_DIRP_update(upd), .from_pipeline_BTB_DIRP_PC(upd_pc),
      .from_pipeline_BTB_target(upd_tgt), .from_pipeline_DIRP_taken(upd_tk),
      .from_pipeline_take_resolved(take), .from_pipeline_resolved_PC(res_pc),
      .from_pipeline_RAS_restore_ptr(rs_ptr), .from_pipeline_RAS_restore_count(rs_cnt),
      .icache_hit(icache_hit), .icache_load(icache_load), .icache_REN(icache_REN),
      .icache_addr(icache_addr), .icache_halt(icache_halt),
      .core_control_stall_fetch_unit(stall), .core_control_halt(halt),
      .to_pipeline_instr(p_instr), .to_pipeline_ivalid(p_ivalid), .to_pipeline_PC(p_pc),
      .to_pipeline_nPC(p_npc), .to_pipeline_RAS_ptr(p_ptr), .to_pipeline_RAS_count(p_cnt));

   always #5 CLK = ~CLK;

   typedef struct packed {
      logic [31:0] ins;
      logic [13:0] pc, npc;
      logic [2:0]  ptr;
      logic [3:0]  cnt;
   } exp_t;
   exp_t exp_q[$];

   int checks = 0, failures = 0;
   int mptr = 0, mcnt = 0;   // bench-side RAS pointer / occupancy

   localparam logic [31:0] NOP = 32'h2108_0001;   // addi
   localparam logic [31:0] BEQ = 32'h1000_0004;
   localparam logic [31:0] BNE = 32'h1400_0004;
   localparam logic [31:0] JR  = 32'h03E0_0008;

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s act=%h exp=%h", name, act, exp);
      end
   endtask

   // Monitor: one expected record per accepted instruction
   always @(negedge CLK) begin
      if (!RST && p_ivalid) begin
         exp_t e, a;
         a = '{p_instr, p_pc, p_npc, p_ptr, p_cnt};
         checks++;
         if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_ivalid pc=%h npc=%h", p_pc, p_npc);
         end else begin
            e = exp_q.pop_front();
            if (a !== e) begin
               failures++;
               $display("FAIL fetch pc=%h npc=%h ptr=%0d cnt=%0d exp pc=%h npc=%h ptr=%0d cnt=%0d",
                        a.pc, a.npc, a.ptr, a.cnt, e.pc, e.npc, e.ptr, e.cnt);
            end
         end
      end
   end

   task automatic issue(logic [31:0] ins, logic [13:0] pc, logic [13:0] npc);
      exp_q.push_back('{ins, pc, npc, 3'(mptr), 4'(mcnt)});
      icache_hit = 1; icache_load = ins;
      @(posedge CLK); #1;
      icache_hit = 0;
      if (ins[31:26] == 6'h03) begin
         mptr = (mptr + 1) % 8;
         if (mcnt < 8) mcnt++;
      end else if (ins == JR && mcnt > 0) begin
         mptr = (mptr + 7) % 8;
         mcnt--;
      end
   endtask

   task automatic redirect(logic [13:0] pc, int rptr, int rcnt);
      take = 1; res_pc = pc; rs_ptr = 3'(rptr); rs_cnt = 4'(rcnt);
      #1 chk("redirect_npc", p_npc, pc);
      @(posedge CLK); #1;
      take = 0;
      mptr = rptr; mcnt = (rcnt > 8) ? 8 : rcnt;
   endtask

   task automatic btb_upd(logic [13:0] pc, logic [13:0] tgt, logic tk);
      upd = 1; upd_pc = pc; upd_tgt = tgt; upd_tk = tk;
      @(posedge CLK); #1;
      upd = 0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state
      repeat (2) @(posedge CLK); #1;
      chk("rst_addr", icache_addr, 32'h40);
      chk("rst_ren", icache_REN, 0);
      chk("rst_halt", icache_halt, 0);
      chk("rst_err", DUT_error, 0);
      chk("rst_pc", p_pc, 14'h010);
      RST = 0;
      @(posedge CLK); #1;
      chk("ren_up", icache_REN, 1);
      chk("no_hit_ivalid", p_ivalid, 0);
      chk("hold_npc", p_npc, 14'h010);

      // Sequential fetch, stall, wrap
      issue(NOP, 14'h010, 14'h011);
      issue(NOP, 14'h011, 14'h012);
      icache_hit = 1; icache_load = NOP; stall = 1;
      #1 chk("stall_ivalid", p_ivalid, 0);
      chk("stall_npc", p_npc, 14'h012);
      @(posedge CLK); #1;
      stall = 0; icache_hit = 0;
      issue(NOP, 14'h012, 14'h013);
      redirect(14'h3FFF, mptr, mcnt);
      issue(NOP, 14'h3FFF, 14'h0000);

      // BTB: two taken updates, an alias, then one not-taken update
      btb_upd(14'h020, 14'h100, 1);
      btb_upd(14'h020, 14'h100, 1);
      redirect(14'h020, mptr, mcnt);
      issue(BEQ, 14'h020, 14'h100);
      redirect(14'h030, mptr, mcnt);
      issue(BEQ, 14'h030, 14'h031);
      btb_upd(14'h020, 14'h100, 0);
      redirect(14'h020, mptr, mcnt);
      issue(BNE, 14'h020, 14'h100);

      // RAS: nine calls overflow an 8-deep stack, then nine returns
      redirect(14'h200, mptr, mcnt);
      for (int k = 0; k < 9; k++)
         issue({6'h03, 26'(14'h210 + 14'h10 * k)}, 14'(14'h200 + 14'h10 * k),
               14'(14'h210 + 14'h10 * k));
      chk("ras_full_cnt", p_cnt, 8);
      for (int j = 0; j < 8; j++)
         issue(JR, (j == 0) ? 14'h290 : 14'(14'h291 - 14'h10 * j), 14'(14'h281 - 14'h10 * j));
      chk("ras_empty_cnt", p_cnt, 0);
      issue(JR, 14'h211, 14'h212);

      // jal on the same cycle as a redirect: no push, RAS restored
      icache_hit = 1; icache_load = {6'h03, 26'h0000500};
      take = 1; res_pc = 14'h300; rs_ptr = 3; rs_cnt = 3;
      #1 chk("rr_ivalid", p_ivalid, 0);
      chk("rr_npc", p_npc, 14'h300);
      chk("rr_ptr_pre", p_ptr, 3'(mptr));
      @(posedge CLK); #1;
      take = 0; icache_hit = 0; mptr = 3; mcnt = 3;
      issue(NOP, 14'h300, 14'h301);

      // Oversized restore count: error pulse and clamp
      redirect(14'h310, 2, 9);
      chk("err_pulse", DUT_error, 1);
      issue(NOP, 14'h310, 14'h311);
      chk("err_clear", DUT_error, 0);

      // Sticky halt
      halt = 1; icache_hit = 1; icache_load = NOP;
      #1 chk("halt_ivalid", p_ivalid, 0);
      @(posedge CLK); #1;
      halt = 0;
      for (int h = 0; h < 3; h++) begin
         chk("halted_ren", icache_REN, 0);
         chk("halted_halt", icache_halt, 1);
         chk("halted_ivalid", p_ivalid, 0);
         @(posedge CLK); #1;
      end
      icache_hit = 0;
      chk("queue_drained", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
